// File: rtl/segmented_mem_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : segmented_mem_ctrl_if
// Purpose  : req/ack data-access bus between a CPU core and segmented_mem_ctrl.
// Revision : 1.0
// ----------------------------------------------------------------------------
interface segmented_mem_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             req;
  logic             we;
  logic [WIDTH-1:0] a2;
  logic [WIDTH-1:0] wd;
  logic             ack;
  logic [WIDTH-1:0] rd2;
  logic             err;
  logic             busy;

  modport master (
    output req, we, a2, wd,
    input  ack, rd2, err, busy
  );

  modport slave (
    input  req, we, a2, wd,
    output ack, rd2, err, busy
  );
endinterface
`default_nettype wire

// File: rtl/segmented_mem_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : segmented_mem_ctrl
// Purpose  : Instruction ROM with registered fetch, NSEG data segments and an
//            MMIO window (START/DONE/CYCLES) behind a wait-stated req/ack port.
// Revision : 1.0
// ----------------------------------------------------------------------------
module segmented_mem_ctrl #(
  parameter int WIDTH     = 32,
  parameter int IWIDTH    = 24,
  parameter int IDEPTH    = 1024,
  parameter int NSEG      = 2,
  parameter int SEG_DEPTH = 102,
  parameter int WAIT      = 0
) (
  input  wire                       clk,
  input  wire                       rst_n,
  // instruction fetch
  input  wire  [WIDTH-1:0]          a1,
  output logic [IWIDTH-1:0]         rd1,
  // instruction image load (boot-time, not used by the CPU)
  input  wire                       imem_we,
  input  wire  [$clog2(IDEPTH)-1:0] imem_wa,
  input  wire  [IWIDTH-1:0]         imem_wd,
  // data access bus
  segmented_mem_ctrl_if.slave       bus,
  // I/O handshake
  input  wire                       start_io,
  output logic                      done_o
);

  localparam int IAW  = $clog2(IDEPTH);
  localparam int OFFW = (SEG_DEPTH > 1) ? $clog2(SEG_DEPTH) : 1;

  localparam logic [WIDTH-1:0] c_mmio_base   = WIDTH'(NSEG * SEG_DEPTH);
  localparam logic [WIDTH-1:0] c_addr_start  = c_mmio_base;
  localparam logic [WIDTH-1:0] c_addr_done   = c_mmio_base + WIDTH'(1);
  localparam logic [WIDTH-1:0] c_addr_cycles = c_mmio_base + WIDTH'(2);
  localparam logic [WIDTH-1:0] c_seg_depth   = WIDTH'(SEG_DEPTH);
  localparam logic [WIDTH-1:0] c_idepth      = WIDTH'(IDEPTH);
  localparam logic [3:0]       c_wait_last   = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAITS = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t             state_q,  state_d;
  logic [3:0]         wcnt_q,   wcnt_d;
  logic               we_q,     we_d;
  logic [WIDTH-1:0]   addr_q,   addr_d;
  logic [WIDTH-1:0]   wd_q,     wd_d;
  logic               ack_q,    ack_d;
  logic [WIDTH-1:0]   rd2_q,    rd2_d;
  logic               err_q,    err_d;
  logic               busy_q,   busy_d;
  logic               start_q,  start_d;
  logic               done_q,   done_d;
  logic [WIDTH-1:0]   cycles_q, cycles_d;
  logic [IWIDTH-1:0]  rd1_q,    rd1_d;

  // --------------------------------------------------------------------------
  // Instruction segment
  // --------------------------------------------------------------------------
  logic [IWIDTH-1:0] imem [IDEPTH];

  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem[imem_wa] <= imem_wd;
    end
  end

  // --------------------------------------------------------------------------
  // Data segments: each decodes its own window from the latched address
  // --------------------------------------------------------------------------
  logic [NSEG-1:0]  seg_hit;
  logic [WIDTH-1:0] seg_rdata [NSEG];
  logic             resp_write;

  // A reset landing on the RESP cycle must discard the pending write.
  assign resp_write = (state_q == ST_RESP) && rst_n && we_q;

  genvar k;
  generate
    for (k = 0; k < NSEG; k++) begin : g_seg
      localparam logic [WIDTH-1:0] c_lo = WIDTH'(k * SEG_DEPTH);

      logic [WIDTH-1:0] seg_mem [SEG_DEPTH];
      logic [WIDTH-1:0] off;

      // Below-window addresses wrap to a huge offset, so one compare suffices.
      assign off          = addr_q - c_lo;
      assign seg_hit[k]   = (off < c_seg_depth);
      assign seg_rdata[k] = seg_hit[k] ? seg_mem[off[OFFW-1:0]] : '0;

      always_ff @(posedge clk) begin
        if (resp_write && seg_hit[k]) begin
          seg_mem[off[OFFW-1:0]] <= wd_q;
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Address decode and read mux
  // --------------------------------------------------------------------------
  logic             is_start;
  logic             is_done;
  logic             is_cycles;
  logic             mapped;
  logic [WIDTH-1:0] rdata;

  assign is_start  = (addr_q == c_addr_start);
  assign is_done   = (addr_q == c_addr_done);
  assign is_cycles = (addr_q == c_addr_cycles);
  assign mapped    = (|seg_hit) || is_start || is_done || is_cycles;

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NSEG; i++) begin
      rdata = rdata | seg_rdata[i];
    end
    if (is_start) begin
      rdata = {{(WIDTH-1){1'b0}}, start_q};
    end
    if (is_done) begin
      rdata = {{(WIDTH-1){1'b0}}, done_q};
    end
    if (is_cycles) begin
      rdata = cycles_q;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wd_d     = wd_q;
    ack_d    = 1'b0;
    rd2_d    = rd2_q;
    err_d    = err_q;
    busy_d   = busy_q;
    start_d  = start_q;
    done_d   = done_q;
    cycles_d = cycles_q + WIDTH'(1);

    rd1_d = (a1 < c_idepth) ? imem[a1[IAW-1:0]] : '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          addr_d  = bus.a2;
          wd_d    = bus.wd;
          busy_d  = 1'b1;
          wcnt_d  = 4'd0;
          state_d = (WAIT > 0) ? ST_WAITS : ST_RESP;
        end
      end
      ST_WAITS: begin
        if (wcnt_q == c_wait_last) begin
          state_d = ST_RESP;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      ST_RESP: begin
        ack_d   = 1'b1;
        busy_d  = 1'b0;
        err_d   = !mapped;
        rd2_d   = rdata;
        state_d = ST_IDLE;
        if (we_q) begin
          if (is_start) begin
            start_d = 1'b0;
          end
          if (is_done) begin
            done_d = wd_q[0];
          end
          if (is_cycles) begin
            cycles_d = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The I/O set has priority over a simultaneous software clear.
    if (start_io) begin
      start_d = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      wcnt_q   <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wd_q     <= '0;
      ack_q    <= 1'b0;
      rd2_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      cycles_q <= '0;
      rd1_q    <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wd_q     <= wd_d;
      ack_q    <= ack_d;
      rd2_q    <= rd2_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
      done_q   <= done_d;
      cycles_q <= cycles_d;
      rd1_q    <= rd1_d;
    end
  end

  assign rd1      = rd1_q;
  assign done_o   = done_q;
  assign bus.ack  = ack_q;
  assign bus.rd2  = rd2_q;
  assign bus.err  = err_q;
  assign bus.busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_segmented_mem_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_segmented_mem_ctrl
// Purpose  : Vector table, directed corner sequences and random traffic
//            checked against an address-map level reference model.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_segmented_mem_ctrl;

  localparam int WIDTH     = 32;
  localparam int IWIDTH    = 24;
  localparam int IDEPTH    = 1024;
  localparam int NSEG      = 2;
  localparam int SEG_DEPTH = 102;
  localparam int WAIT      = 2;
  localparam int NDATA     = NSEG * SEG_DEPTH;   // 204
  localparam logic [31:0] A_START  = 32'd204;
  localparam logic [31:0] A_DONE   = 32'd205;
  localparam logic [31:0] A_CYCLES = 32'd206;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [WIDTH-1:0]  a1;
  logic [IWIDTH-1:0] rd1;
  logic              imem_we;
  logic [9:0]        imem_wa;
  logic [IWIDTH-1:0] imem_wd;
  logic              start_io;
  logic              done_o;

  segmented_mem_ctrl_if #(.WIDTH(WIDTH)) bus ();

  segmented_mem_ctrl #(
    .WIDTH(WIDTH), .IWIDTH(IWIDTH), .IDEPTH(IDEPTH),
    .NSEG(NSEG), .SEG_DEPTH(SEG_DEPTH), .WAIT(WAIT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a1       (a1),
    .rd1      (rd1),
    .imem_we  (imem_we),
    .imem_wa  (imem_wa),
    .imem_wd  (imem_wd),
    .bus      (bus),
    .start_io (start_io),
    .done_o   (done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0]       m_mem  [NDATA];
  logic [IWIDTH-1:0] m_imem [IDEPTH];
  logic              m_start;
  logic              m_done;
  int                m_load_cyc;   // edge index at which CYCLES last became 0

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        exp_done;
  } vec_t;

  vec_t vt [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Issue one access starting in an idle cycle; returns data, err, latency
  // in edges after the accepting edge (-1 on timeout) and the ack edge index.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] r, output logic e,
                        output int lat, output int ack_cyc);
    bus.req = 1'b1; bus.we = w; bus.a2 = a; bus.wd = d;
    tick();
    bus.req = 1'b0;
    lat = 1;
    tick();
    while (bus.ack !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    if (bus.ack !== 1'b1) lat = -1;
    r = bus.rd2;
    e = bus.err;
    ack_cyc = cyc;
  endtask

  // Address-map semantics: returns expected read data / err, applies writes.
  task automatic model_op(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input int ack_cyc, output logic [31:0] er, output logic ee);
    er = '0;
    ee = 1'b0;
    if (a < NDATA) begin
      er = m_mem[a];
      if (w) m_mem[a] = d;
    end else if (a == A_START) begin
      er = {31'b0, m_start};
      if (w) m_start = 1'b0;
    end else if (a == A_DONE) begin
      er = {31'b0, m_done};
      if (w) m_done = d[0];
    end else if (a == A_CYCLES) begin
      // value seen in the cycle before ack = edges elapsed since the load edge
      er = 32'(ack_cyc - 1 - m_load_cyc);
      if (w) m_load_cyc = ack_cyc;
    end else begin
      ee = 1'b1;
    end
  endtask

  task automatic op(input string nm, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r, er;
    logic        e, ee;
    int          lat, ac;
    access(w, a, d, r, e, lat, ac);
    model_op(w, a, d, ac, er, ee);
    chk({nm, " latency"}, 32'(lat), 32'(WAIT + 1));
    chk({nm, " err"}, {31'b0, e}, {31'b0, ee});
    if (!w || ee) chk({nm, " rd2"}, r, er);
    chk({nm, " done_o"}, {31'b0, done_o}, {31'b0, m_done});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic        e;
    logic [31:0] er;
    logic        ee;
    int          lat, ac, nacks, v0;

    vt[0]  = '{1'b1, 32'd101,        32'h11,        1'b0, 32'h0,        1'b0, 1'b0};
    vt[1]  = '{1'b1, 32'd102,        32'h22,        1'b0, 32'h0,        1'b0, 1'b0};
    vt[2]  = '{1'b0, 32'd101,        32'h0,         1'b1, 32'h11,       1'b0, 1'b0};
    vt[3]  = '{1'b0, 32'd102,        32'h0,         1'b1, 32'h22,       1'b0, 1'b0};
    vt[4]  = '{1'b0, 32'd0,          32'h0,         1'b1, 32'hA5000000, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 32'd203,        32'h0,         1'b1, 32'hA50000CB, 1'b0, 1'b0};
    vt[6]  = '{1'b1, 32'd300,        32'hDEAD,      1'b1, 32'h0,        1'b1, 1'b0};
    vt[7]  = '{1'b0, 32'd300,        32'h0,         1'b1, 32'h0,        1'b1, 1'b0};
    vt[8]  = '{1'b0, 32'd207,        32'h0,         1'b1, 32'h0,        1'b1, 1'b0};
    vt[9]  = '{1'b1, 32'd205,        32'h1,         1'b0, 32'h0,        1'b0, 1'b1};
    vt[10] = '{1'b0, 32'd205,        32'h0,         1'b1, 32'h1,        1'b0, 1'b1};
    vt[11] = '{1'b1, 32'd205,        32'hFFFFFFFE,  1'b0, 32'h0,        1'b0, 1'b0};
    vt[12] = '{1'b0, 32'd205,        32'h0,         1'b1, 32'h0,        1'b0, 1'b0};
    vt[13] = '{1'b1, 32'd203,        32'h33,        1'b0, 32'h0,        1'b0, 1'b0};
    vt[14] = '{1'b0, 32'd203,        32'h0,         1'b1, 32'h33,       1'b0, 1'b0};
    vt[15] = '{1'b0, 32'hFFFFFFFF,   32'h0,         1'b1, 32'h0,        1'b1, 1'b0};

    a1 = '0; imem_we = 1'b0; imem_wa = '0; imem_wd = '0; start_io = 1'b0;
    bus.req = 1'b0; bus.we = 1'b0; bus.a2 = '0; bus.wd = '0;
    m_start = 1'b0; m_done = 1'b0;

    // T1 reset
    rst_n = 1'b0;
    tick(); tick();
    chk("reset rd1",    {8'b0, rd1},          32'h0);
    chk("reset rd2",    bus.rd2,              32'h0);
    chk("reset ack",    {31'b0, bus.ack},     32'h0);
    chk("reset err",    {31'b0, bus.err},     32'h0);
    chk("reset busy",   {31'b0, bus.busy},    32'h0);
    chk("reset done_o", {31'b0, done_o},      32'h0);
    rst_n = 1'b1;
    m_load_cyc = cyc;
    op("cycles after reset 1", 1'b0, A_CYCLES, 32'h0);
    v0 = int'(bus.rd2);
    op("cycles after reset 2", 1'b0, A_CYCLES, 32'h0);
    chk("cycles increasing", {31'b0, (int'(bus.rd2) > v0 && v0 < 20)}, 32'h1);

    // T2 instruction fetch
    imem_we = 1'b1;
    imem_wa = 10'd5; imem_wd = 24'hABCDEF; m_imem[5] = 24'hABCDEF; tick();
    imem_wa = 10'd6; imem_wd = 24'h123456; m_imem[6] = 24'h123456; tick();
    for (int i = 100; i < 116; i++) begin
      imem_wa = 10'(i);
      imem_wd = 24'($urandom);
      m_imem[i] = imem_wd;
      tick();
    end
    imem_we = 1'b0;
    a1 = 32'd6; tick();
    a1 = 32'd5;
    chk("fetch before edge", {8'b0, rd1}, 32'h123456);
    tick();
    chk("fetch a1=5", {8'b0, rd1}, 32'hABCDEF);
    a1 = IDEPTH; tick();
    chk("fetch a1=IDEPTH", {8'b0, rd1}, 32'h0);
    a1 = 32'hFFFFFFFF; tick();
    chk("fetch a1=max", {8'b0, rd1}, 32'h0);
    for (int i = 0; i < 12; i++) begin
      a1 = 32'($urandom_range(100, 115));
      tick();
      chk("fetch random", {8'b0, rd1}, {8'b0, m_imem[a1]});
    end

    // Prefill every data word with a known pattern
    for (int i = 0; i < NDATA; i++) begin
      op("prefill", 1'b1, 32'(i), 32'hA5000000 | 32'(i));
    end

    // T3 / table vectors
    for (int i = 0; i < 16; i++) begin
      access(vt[i].we, vt[i].a, vt[i].wd, r, e, lat, ac);
      model_op(vt[i].we, vt[i].a, vt[i].wd, ac, er, ee);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(WAIT + 1));
      chk($sformatf("vec%0d err", i), {31'b0, e}, {31'b0, vt[i].exp_err});
      if (vt[i].chk_rd) chk($sformatf("vec%0d rd2", i), r, vt[i].exp_rd);
      chk($sformatf("vec%0d done_o", i), {31'b0, done_o}, {31'b0, vt[i].exp_done});
    end

    // T4 START / DONE / CYCLES
    start_io = 1'b1; tick(); start_io = 1'b0; m_start = 1'b1;
    op("start read set", 1'b0, A_START, 32'h0);
    op("start sticky", 1'b0, A_START, 32'h0);
    op("start write", 1'b1, A_START, 32'h0);
    op("start read cleared", 1'b0, A_START, 32'h0);
    op("done write 1", 1'b1, A_DONE, 32'h1);
    op("cycles write", 1'b1, A_CYCLES, 32'h12345678);
    op("cycles read back", 1'b0, A_CYCLES, 32'h0);
    tick(); tick(); tick();
    op("cycles read later", 1'b0, A_CYCLES, 32'h0);

    // T5 simultaneous set and clear of START: set wins
    start_io = 1'b1;
    op("start set+clear write", 1'b1, A_START, 32'h0);
    start_io = 1'b0;
    m_start = 1'b1;
    op("start set wins", 1'b0, A_START, 32'h0);

    // T5 req held while busy: second request must be ignored
    op("busy pre 11", 1'b0, 32'd11, 32'h0);
    bus.req = 1'b1; bus.we = 1'b1; bus.a2 = 32'd10; bus.wd = 32'hAA;
    tick();
    chk("busy asserted", {31'b0, bus.busy}, 32'h1);
    bus.a2 = 32'd11; bus.wd = 32'hBB;
    nacks = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) bus.req = 1'b0;
      tick();
      if (bus.ack === 1'b1) nacks++;
    end
    chk("busy single ack", 32'(nacks), 32'd1);
    m_mem[10] = 32'hAA;
    op("busy first write landed", 1'b0, 32'd10, 32'h0);
    op("busy second write ignored", 1'b0, 32'd11, 32'h0);

    // T6 reset during WAITS
    bus.req = 1'b1; bus.we = 1'b1; bus.a2 = 32'd50; bus.wd = 32'hCAFEF00D;
    tick();
    bus.req = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_load_cyc = cyc;
    m_start = 1'b0;
    m_done  = 1'b0;
    nacks = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.ack === 1'b1) nacks++;
      tick();
    end
    chk("midreset no ack", 32'(nacks), 32'd0);
    chk("midreset busy", {31'b0, bus.busy}, 32'h0);
    chk("midreset done_o", {31'b0, done_o}, 32'h0);
    op("midreset word unchanged", 1'b0, 32'd50, 32'h0);
    op("midreset cycles", 1'b0, A_CYCLES, 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      int      sel;
      logic    w;
      logic [31:0] a;
      sel = $urandom_range(0, 99);
      w   = 1'($urandom_range(0, 1));
      if (sel < 70)      a = 32'($urandom_range(0, NDATA - 1));
      else if (sel < 78) a = A_DONE;
      else if (sel < 84) a = A_START;
      else if (sel < 89) a = A_CYCLES;
      else if (sel < 95) a = 32'($urandom_range(207, 5000));
      else               a = $urandom;
      if ($urandom_range(0, 9) == 0) begin
        start_io = 1'b1; tick(); start_io = 1'b0;
        m_start = 1'b1;
      end
      if ($urandom_range(0, 4) == 0) tick();
      op($sformatf("rand%0d a=%0d", n, a), w, a, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
